cmp_stim_checker: RTL

On-board self-test driver and checker for the 4-bit signed/unsigned magnitude comparator. It drives the comparator's operand and mode inputs, which are wired in place of the SW[7:4], SW[3:0] and SW[8] switches. It walks every operand pair, reads back the comparator's three LED outputs and checks each against an internal golden compare. It reports pass/fail, an error count and the first failing pair.

---
 rtl/cmp_chk_pkg.sv | 21 ++
 rtl/hex7seg_dec.sv | 32 +++
 rtl/cmp_stim_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cmp_chk_pkg.sv
// Shared definitions for the comparator self-test checker.
//   state_t  : sweep FSM states
//   GT/EQ/LT : bit positions inside the {gt,eq,lt} result vector
//   ERR_MAX  : saturation value of the mismatch counter
package cmp_chk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int GT = 2;
    localparam int EQ = 1;
    localparam int LT = 0;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/hex7seg_dec.sv
// Hex digit to seven-segment decoder.
//   nibble : 4-bit value to display (0-F)
//   seg    : {dp, g, f, e, d, c, b, a}, active low; dp is always off
module hex7seg_dec (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/cmp_stim_checker.sv
// Self-test driver/checker for a WIDTH-bit signed/unsigned magnitude comparator.
// Walks every {a,b} operand pair, waits SETTLE cycles, samples the comparator's
// {gt,eq,lt} indications and checks them against a golden compare.
//
// Ports:
//   CLK_50, RESET_N        : clock, asynchronous active-low reset
//   start, signed_mode     : sweep request and mode (mode latched with start)
//   a_out, b_out, sgn_out  : operands and mode driven to the comparator
//   dut_gt, dut_eq, dut_lt : comparator result indications
//   busy, done, pass       : sweep status; pass valid while done
//   err_count, first_fail  : saturating mismatch count, {a,b} of first mismatch
//   HEX0, HEX1             : err_count nibbles on active-low 7-seg displays
//
// Build option: define CMP_HEX_EN to drive HEX0/HEX1 through hex7seg_dec;
// otherwise both displays are constant 8'hFF (blank).
//
// Handshake: start is a single-cycle request accepted only while busy is low
// (IDLE or DONE). Once accepted, busy stays high until the final pair has been
// checked; requests arriving while busy is high are dropped.
module cmp_stim_checker
    import cmp_chk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 CLK_50,
    input  logic                 RESET_N,
    input  logic                 start,
    input  logic                 signed_mode,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 sgn_out,
    input  logic                 dut_gt,
    input  logic                 dut_eq,
    input  logic                 dut_lt,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [2*WIDTH-1:0]   first_fail,
    output logic [7:0]           HEX0,
    output logic [7:0]           HEX1
);

    state_t               state;
    logic [2*WIDTH-1:0]   idx;
    logic                 mode_q;
    logic                 have_fail;   // first_fail == 0 is a legal pair, so track validity separately
    logic [3:0]           settle_cnt;

    logic [2:0]           exp_vec;
    logic [2:0]           got_vec;
    logic                 mismatch;
    logic [7:0]           err_next;

    // One-hot golden compare; operands are sign- or zero-extended by one bit
    // so a single signed compare covers both modes.
    function automatic logic [2:0] golden(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic             sgn);
        logic [WIDTH:0] ax;
        logic [WIDTH:0] bx;
        logic [2:0]     r;
        ax = {sgn & a[WIDTH-1], a};
        bx = {sgn & b[WIDTH-1], b};
        r  = 3'b000;
        if ($signed(ax) > $signed(bx))
            r[GT] = 1'b1;
        else if (ax == bx)
            r[EQ] = 1'b1;
        else
            r[LT] = 1'b1;
        return r;
    endfunction

    always_comb begin
        got_vec     = 3'b000;
        got_vec[GT] = dut_gt;
        got_vec[EQ] = dut_eq;
        got_vec[LT] = dut_lt;
        exp_vec     = golden(a_out, b_out, sgn_out);
        mismatch    = (got_vec != exp_vec);
        err_next    = (err_count == ERR_MAX) ? err_count : err_count + 8'd1;
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            idx        <= '0;
            mode_q     <= 1'b0;
            have_fail  <= 1'b0;
            settle_cnt <= '0;
            a_out      <= '0;
            b_out      <= '0;
            sgn_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                // DONE restarts with the same semantics as IDLE; operands keep
                // their last value until the first DRIVE of the new sweep.
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        mode_q     <= signed_mode;
                        idx        <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        have_fail  <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                DRIVE: begin
                    a_out      <= idx[2*WIDTH-1:WIDTH];
                    b_out      <= idx[WIDTH-1:0];
                    sgn_out    <= mode_q;
                    settle_cnt <= 4'(SETTLE - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (settle_cnt == 4'd0)
                        state <= CHECK;
                    else
                        settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!have_fail) begin
                            first_fail <= {a_out, b_out};
                            have_fail  <= 1'b1;
                        end
                    end
                    if (&idx) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == 8'd0);
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMP_HEX_EN
    // Displays stay blank until a sweep has been started so that reset shows 8'hFF.
    logic [7:0] seg_lo;
    logic [7:0] seg_hi;

    hex7seg_dec u_hex_lo (.nibble(err_count[3:0]), .seg(seg_lo));
    hex7seg_dec u_hex_hi (.nibble(err_count[7:4]), .seg(seg_hi));

    assign HEX0 = (busy || done) ? seg_lo : 8'hFF;
    assign HEX1 = (busy || done) ? seg_hi : 8'hFF;
`else
    assign HEX0 = 8'hFF;
    assign HEX1 = 8'hFF;
`endif

endmodule
